mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous active-low reset: CLK (clock) and RST_N (reset), listed as the first two ports below.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction fetch request; held high until granted.
REQ-005 i_addr  input  32  fetch byte address; always a word access (size 010).
REQ-006 i_gnt  output  1  fetch accepted this cycle (combinational).
REQ-007 i_valid  output  1  fetch response cycle.
REQ-008 i_err  output  1  fetch misaligned; qualified by i_valid.
REQ-009 d_req  input  1  load/store request; held high until granted.
REQ-010 d_wr  input  1  1 = store, 0 = load.
REQ-011 d_size  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data, right-aligned.
REQ-014 d_gnt  output  1  data request accepted this cycle (combinational).
REQ-015 d_valid  output  1  data response cycle (loads and stores).
REQ-016 d_err  output  1  misaligned or illegal size; qualified by d_valid.
REQ-017 rdata  output  32  load/fetch data; valid when i_valid or d_valid.
REQ-018 mem_en  output  1  memory enable (issue cycle only).
REQ-019 mem_wr  output  1  memory write strobe.
REQ-020 mem_addr  output  32  memory address.
REQ-021 mem_size  output  3  memory size code.
REQ-022 mem_wdata  output  32  memory write data.
REQ-023 mem_rdata  input  32  memory formatted read data (1-cycle RAM latency, combinational formatting on mem_addr/mem_size).

Function
REQ-024 FSM states SHALL be IDLE, RESP_I, RESP_D; a grant occurs only in IDLE, at most one grant per cycle.
REQ-025 In IDLE with a request pending, the winner SHALL get gnt, mem_addr/mem_size driven from its inputs, and the FSM SHALL go to RESP_I or RESP_D.
REQ-026 In RESP_x, mem_addr/mem_size SHALL hold the registered granted values, mem_en=mem_wr=0, x_valid=1, rdata=mem_rdata (0 for stores/errors); the next state SHALL be IDLE.
REQ-027 Latency SHALL be exactly one cycle from gnt to valid; throughput one access per two cycles; a new grant is possible in the cycle after valid.
REQ-028 Misaligned data (h with addr[0]=1, w with addr[1:0]!=0) or illegal d_size SHALL be granted with mem_en=mem_wr=0 and answered with d_err=1, rdata=0.
REQ-029 Fetch with i_addr[1:0]!=0 SHALL be granted without memory access and answered with i_err=1, rdata=0.
REQ-030 For legal stores: mem_en=mem_wr=1 in the grant cycle only; mem_wdata=d_wdata; d_valid follows with rdata=0.
REQ-031 With both requests in the same IDLE cycle, priority SHALL follow REQ-036/037; the loser's gnt SHALL stay 0 and its request remains pending.
REQ-032 Requests arriving in RESP_x SHALL be ignored until IDLE; no request is dropped while held high.

Reset
REQ-033 On RST_N low, immediately: state=IDLE; i_gnt, d_gnt, i_valid, d_valid, i_err, d_err, mem_en, mem_wr=0; rdata=0; held addr/size=0.
REQ-034 Reset asserted in RESP_x SHALL abort the response (no valid issued after release); a write already strobed is not undone.

Configuration
REQ-035 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-036 Defined: on simultaneous requests, the requester not granted last wins (last-grant register reset to "instruction", so data wins first).
REQ-037 Undefined: the data port always wins; instruction is granted only when d_req=0.

Verification
REQ-038 Fetch i_addr=0x10, memory word 0xDEADBEEF -> i_gnt cycle N, i_valid cycle N+1, rdata=0xDEADBEEF, i_err=0.
REQ-039 Store byte d_addr=0x21, d_wdata=0xAB, then lbu 0x21 -> mem_wr 1 cycle; load rdata=0x000000AB; lb of 0x80 yields 0xFFFFFF80.
REQ-040 Word store at 0x22 -> d_err=1 at N+1, mem_wr never asserted, memory unchanged.
REQ-041 i_req and d_req held 6 cycles -> undefined macro: D,D,D grants; defined: D,I,D alternating.
REQ-042 RST_N low during RESP_D -> all outputs 0 immediately; after release no d_valid until a new grant.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports and RAM port of mem_arbiter.
// slave = arbiter side, master = core and RAM side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic        i_err;
  logic        d_req;
  logic        d_wr;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic        d_err;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    input  mem_rdata,
    output i_gnt, i_valid, i_err,
    output d_gnt, d_valid, d_err, rdata,
    output mem_en, mem_wr, mem_addr,
    output mem_size, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    output mem_rdata,
    input  i_gnt, i_valid, i_err,
    input  d_gnt, d_valid, d_err, rdata,
    input  mem_en, mem_wr, mem_addr,
    input  mem_size, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter onto a single 1-cycle RAM port.
// ARB_ROUND_ROBIN_EN: alternate on conflicts, else data always wins.
module mem_arbiter (
  input  logic         CLK,
  input  logic         RST_N,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RESP_I,
    RESP_D
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        err_q;
  logic        zero_q;
  logic        i_valid_q;
  logic        d_valid_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d_q;
`endif

  logic idle;
  logic d_win;
  logic i_win;
  logic d_ok;
  logic d_mis;
  logic d_bad;
  logic i_bad;

  // Gating with RST_N keeps grants low while reset is held.
  assign idle = (state_q == IDLE) & RST_N;

  always_comb begin
    d_ok  = 1'b0;
    d_mis = 1'b0;
    unique case (bus.d_size)
      3'b000, 3'b100: d_ok = 1'b1;
      3'b001, 3'b101: begin
        d_ok  = 1'b1;
        d_mis = bus.d_addr[0];
      end
      3'b010: begin
        d_ok  = 1'b1;
        d_mis = |bus.d_addr[1:0];
      end
      default: ;
    endcase
  end

  assign d_bad = ~d_ok | d_mis;
  assign i_bad = |bus.i_addr[1:0];

`ifdef ARB_ROUND_ROBIN_EN
  assign d_win = idle & bus.d_req
               & (~bus.i_req | ~last_d_q);
`else
  assign d_win = idle & bus.d_req;
`endif
  assign i_win = idle & bus.i_req & ~d_win;

  assign bus.d_gnt = d_win;
  assign bus.i_gnt = i_win;

  assign bus.mem_en = (d_win & ~d_bad)
                    | (i_win & ~i_bad);
  assign bus.mem_wr = d_win & ~d_bad & bus.d_wr;
  assign bus.mem_wdata = d_win ? bus.d_wdata : '0;

  always_comb begin
    bus.mem_addr = addr_q;
    bus.mem_size = size_q;
    if (d_win) begin
      bus.mem_addr = bus.d_addr;
      bus.mem_size = bus.d_size;
    end else if (i_win) begin
      bus.mem_addr = bus.i_addr;
      bus.mem_size = 3'b010;
    end
  end

  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.i_err   = i_valid_q & err_q;
  assign bus.d_err   = d_valid_q & err_q;
  assign bus.rdata   =
    ((i_valid_q | d_valid_q) & ~zero_q)
      ? bus.mem_rdata : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q   <= RESP_D;
            addr_q    <= bus.d_addr;
            size_q    <= bus.d_size;
            err_q     <= d_bad;
            zero_q    <= d_bad | bus.d_wr;
            d_valid_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b1;
`endif
          end else if (i_win) begin
            state_q   <= RESP_I;
            addr_q    <= bus.i_addr;
            size_q    <= 3'b010;
            err_q     <= i_bad;
            zero_q    <= i_bad;
            i_valid_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
          end
        end
        RESP_I, RESP_D: state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the DUT
  logic [7:0] emem [256] = '{default: 8'h00};
  // reference model memory
  logic [7:0] mmem [256] = '{default: 8'h00};

  logic [7:0] ea;
  always_comb begin
    ea = bus.mem_addr[7:0];
    bus.mem_rdata = '0;
    case (bus.mem_size)
      3'b000: bus.mem_rdata = {{24{emem[ea][7]}}, emem[ea]};
      3'b100: bus.mem_rdata = {24'h0, emem[ea]};
      3'b001: bus.mem_rdata = {{16{emem[ea+8'd1][7]}},
                               emem[ea+8'd1], emem[ea]};
      3'b101: bus.mem_rdata = {16'h0, emem[ea+8'd1], emem[ea]};
      3'b010: bus.mem_rdata = {emem[ea+8'd3], emem[ea+8'd2],
                               emem[ea+8'd1], emem[ea]};
      default: bus.mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) begin
      case (bus.mem_size[1:0])
        2'b00: emem[bus.mem_addr[7:0]] = bus.mem_wdata[7:0];
        2'b01: begin
          emem[bus.mem_addr[7:0]]       = bus.mem_wdata[7:0];
          emem[bus.mem_addr[7:0]+8'd1]  = bus.mem_wdata[15:8];
        end
        2'b10: begin
          emem[bus.mem_addr[7:0]]       = bus.mem_wdata[7:0];
          emem[bus.mem_addr[7:0]+8'd1]  = bus.mem_wdata[15:8];
          emem[bus.mem_addr[7:0]+8'd2]  = bus.mem_wdata[23:16];
          emem[bus.mem_addr[7:0]+8'd3]  = bus.mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'b00) return 1;
    if (s[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_bad(input logic [31:0] a,
                                   input logic [2:0] s);
    if (!(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             input logic [2:0] s);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = 0;
    for (int k = 0; k < n; k++)
      v = v + (32'(mmem[8'(a + k)]) << (8 * k));
    if (s[2] == 1'b0 && n < 4 && v[8*n-1])
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic clr_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_size  = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_d(input logic wr, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.d_req   = 1'b1;
    bus.d_wr    = wr;
    bus.d_size  = s;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.i_err,
         bus.d_err, bus.mem_en, bus.mem_wr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid,
                bus.i_err, bus.d_err, bus.mem_en, bus.mem_wr});
    end
    checks++;
    if (bus.rdata !== 0 || bus.mem_addr !== 0 || bus.mem_size !== 0) begin
      errors++;
      $display("FAIL reset_data: rdata %h addr %h size %b required 0",
               bus.rdata, bus.mem_addr, bus.mem_size);
    end
    clr_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    drive_d(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_wr} !== 3'b111) begin
      errors++;
      $display("FAIL sw_grant: got %b required 111",
               {bus.d_gnt, bus.mem_en, bus.mem_wr});
    end
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.d_valid, bus.d_err} !== 2'b10 || bus.rdata !== 0) begin
      errors++;
      $display("FAIL sw_resp: valid/err %b rdata %h required 10 0",
               {bus.d_valid, bus.d_err}, bus.rdata);
    end
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_wr} !== 4'b1010) begin
      errors++;
      $display("FAIL fetch_grant: got %b required 1010",
               {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_wr});
    end
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.i_valid, bus.i_err, bus.mem_en} !== 3'b100 ||
        bus.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_resp: v/e/en %b rdata %h required 100 deadbeef",
               {bus.i_valid, bus.i_err, bus.mem_en}, bus.rdata);
    end
  endtask

  task automatic test_store_load();
    drive_d(1'b1, 3'b000, 32'h21, 32'h000000AB);
    @(negedge clk);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'hAB) begin
      errors++;
      $display("FAIL sb_strobe: wr %b wdata %h required 1 000000ab",
               bus.mem_wr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.d_valid !== 1'b1) begin
      errors++;
      $display("FAIL sb_one_cycle: wr %b valid %b required 0 1",
               bus.mem_wr, bus.d_valid);
    end
    drive_d(1'b0, 3'b100, 32'h21, 32'h0);
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (bus.d_valid !== 1'b1 || bus.rdata !== 32'h000000AB) begin
      errors++;
      $display("FAIL lbu: valid %b rdata %h required 1 000000ab",
               bus.d_valid, bus.rdata);
    end
    drive_d(1'b1, 3'b000, 32'h30, 32'h00000080);
    @(posedge clk);
    #1;
    clr_inputs();
    drive_d(1'b0, 3'b000, 32'h30, 32'h0);
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (bus.rdata !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_sign: rdata %h required ffffff80", bus.rdata);
    end
  endtask

  task automatic test_misaligned();
    drive_d(1'b1, 3'b010, 32'h22, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_wr} !== 3'b100) begin
      errors++;
      $display("FAIL sw_mis_grant: got %b required 100",
               {bus.d_gnt, bus.mem_en, bus.mem_wr});
    end
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.d_valid, bus.d_err, bus.mem_wr} !== 3'b110 ||
        bus.rdata !== 0) begin
      errors++;
      $display("FAIL sw_mis_resp: v/e/wr %b rdata %h required 110 0",
               {bus.d_valid, bus.d_err, bus.mem_wr}, bus.rdata);
    end
    drive_d(1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (bus.rdata !== 32'h0000AB00) begin
      errors++;
      $display("FAIL mem_unchanged: rdata %h required 0000ab00",
               bus.rdata);
    end
    drive_d(1'b0, 3'b011, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.d_valid, bus.d_err} !== 2'b11 || bus.rdata !== 0) begin
      errors++;
      $display("FAIL illegal_size: v/e %b rdata %h required 11 0",
               {bus.d_valid, bus.d_err}, bus.rdata);
    end
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h13;
    @(negedge clk);
    checks++;
    if ({bus.i_gnt, bus.mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_mis_grant: gnt/en %b required 10",
               {bus.i_gnt, bus.mem_en});
    end
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.i_valid, bus.i_err} !== 2'b11 || bus.rdata !== 0) begin
      errors++;
      $display("FAIL fetch_mis_resp: v/e %b rdata %h required 11 0",
               {bus.i_valid, bus.i_err}, bus.rdata);
    end
  endtask

  task automatic test_priority();
    logic [1:0] exp_seq [6];
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
`else
    exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`endif
    do_reset();
    @(posedge clk);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_size = 3'b010;
    bus.d_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== exp_seq[c]) begin
        errors++;
        $display("FAIL prio_c%0d: {i_gnt,d_gnt} %b required %b",
                 c, {bus.i_gnt, bus.d_gnt}, exp_seq[c]);
      end
    end
    @(posedge clk);
    #1;
    clr_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_resp();
    drive_d(1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rr_grant: d_gnt %b required 1", bus.d_gnt);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.i_err,
         bus.d_err, bus.mem_en, bus.mem_wr} !== 8'h00 ||
        bus.rdata !== 0 || bus.mem_addr !== 0) begin
      errors++;
      $display("FAIL rst_in_resp: ctrl %b rdata %h addr %h required 0",
               {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid,
                bus.i_err, bus.d_err, bus.mem_en, bus.mem_wr},
               bus.rdata, bus.mem_addr);
    end
    clr_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.i_valid, bus.d_valid} !== 2'b00) begin
        errors++;
        $display("FAIL no_valid_after_rst_c%0d: valids %b required 00",
                 c, {bus.i_valid, bus.d_valid});
      end
    end
    drive_d(1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (bus.d_valid !== 1'b1 || bus.rdata !== 32'h0000AB00) begin
      errors++;
      $display("FAIL load_after_rst: valid %b rdata %h required 1 0000ab00",
               bus.d_valid, bus.rdata);
    end
  endtask

  task automatic test_random();
    int          resp;
    int          resp_n;
    int          r;
    bit          gi;
    bit          gd;
    bit          wi;
    bit          wd;
    bit          bad;
    bit          exp_err;
    bit          exp_en;
    bit          exp_wr;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [2:0]  s;
`ifdef ARB_ROUND_ROBIN_EN
    bit          last_d;
    last_d = 1'b0;
`endif
    do_reset();
    resp    = 0;
    gi      = 1'b0;
    gd      = 1'b0;
    exp_err = 1'b0;
    exp_rd  = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (!bus.i_req || gi) begin
        a = 32'h80 | 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        bus.i_req  = 1'($urandom_range(0, 1));
        bus.i_addr = a;
      end
      if (!bus.d_req || gd) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1:    s = 3'b000;
          2:       s = 3'b100;
          3, 4:    s = 3'b001;
          5:       s = 3'b101;
          6, 7, 8: s = 3'b010;
          default: s = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b111;
        endcase
        a = 32'h80 | 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) begin
          if (nbytes(s) == 2) a[0] = 1'b0;
          if (nbytes(s) == 4) a[1:0] = 2'b00;
        end
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_wr    = 1'($urandom_range(0, 1));
        bus.d_size  = s;
        bus.d_addr  = a;
        bus.d_wdata = $urandom;
      end
      @(negedge clk);
      checks++;
      if ({bus.i_valid, bus.d_valid} !== {resp == 1, resp == 2}) begin
        errors++;
        $display("FAIL rnd_valid_c%0d: {i,d} %b required %b", c,
                 {bus.i_valid, bus.d_valid}, {resp == 1, resp == 2});
      end
      if (resp != 0) begin
        checks++;
        if ((bus.i_err | bus.d_err) !== exp_err ||
            bus.rdata !== exp_rd) begin
          errors++;
          $display("FAIL rnd_resp_c%0d: err %b rdata %h required %b %h",
                   c, bus.i_err | bus.d_err, bus.rdata, exp_err, exp_rd);
        end
      end
      wi = 1'b0;
      wd = 1'b0;
      if (resp == 0) begin
        if (bus.d_req && bus.i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_d) wi = 1'b1;
          else        wd = 1'b1;
`else
          wd = 1'b1;
`endif
        end else begin
          wd = bus.d_req;
          wi = bus.i_req;
        end
      end
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== {wi, wd}) begin
        errors++;
        $display("FAIL rnd_gnt_c%0d: {i,d} %b required %b", c,
                 {bus.i_gnt, bus.d_gnt}, {wi, wd});
      end
      exp_en = 1'b0;
      exp_wr = 1'b0;
      resp_n = 0;
      if (wd) begin
        bad     = model_bad(bus.d_addr, bus.d_size);
        exp_en  = !bad;
        exp_wr  = !bad && bus.d_wr;
        exp_err = bad;
        exp_rd  = (bad || bus.d_wr) ? 32'h0
                : model_read(bus.d_addr, bus.d_size);
        if (exp_wr)
          for (int k = 0; k < nbytes(bus.d_size); k++)
            mmem[8'(bus.d_addr + k)] = 8'(bus.d_wdata >> (8 * k));
        resp_n = 2;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = 1'b1;
`endif
      end else if (wi) begin
        bad     = (bus.i_addr % 4) != 0;
        exp_en  = !bad;
        exp_err = bad;
        exp_rd  = bad ? 32'h0 : model_read(bus.i_addr, 3'b010);
        resp_n  = 1;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = 1'b0;
`endif
      end
      checks++;
      if ({bus.mem_en, bus.mem_wr} !== {exp_en, exp_wr}) begin
        errors++;
        $display("FAIL rnd_mem_c%0d: {en,wr} %b required %b", c,
                 {bus.mem_en, bus.mem_wr}, {exp_en, exp_wr});
      end
      if (wi || wd) begin
        checks++;
        if (bus.mem_addr !== (wd ? bus.d_addr : bus.i_addr)) begin
          errors++;
          $display("FAIL rnd_addr_c%0d: mem_addr %h required %h", c,
                   bus.mem_addr, wd ? bus.d_addr : bus.i_addr);
        end
      end
      gi   = wi;
      gd   = wd;
      resp = resp_n;
    end
    @(posedge clk);
    #1;
    clr_inputs();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_fetch();
    test_store_load();
    test_misaligned();
    test_priority();
    test_reset_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
